// File: rtl/splitstreamer_core.sv
// splitstreamer_core: left-justified I2S (24-bit) to S/PDIF biphase-mark streamer; SPDIF_CHSTAT_EN enables consumer channel-status bits
module splitstreamer_core (
  input  logic pin_i2s_bclk_pll,
  input  logic pin_user_sw,
  input  logic pin_i2s_fclk,
  input  logic pin_i2s_bclk,
  input  logic pin_i2s_data,
  output logic pin_opt1,
  output logic red
);
  logic clk, rst_n;
  logic [2:0] b_s;
  logic [1:0] f_s, d_s;
  logic rise, chg, frise;
  logic fl, fv, wv;
  logic [4:0] bc;
  logic [23:0] w, hl, bl, br;
  logic [7:0] id, pc;
  logic pv, lock;
  logic [1:0] gc;
  logic [6:0] c;
  logic [7:0] fr;
  logic [23:0] smp;
  logic pl, cb, bit_v, pre_lvl, nxt;
  logic [4:0] slot;
  logic [7:0] pat;
  assign clk = pin_i2s_bclk_pll;
  assign rst_n = pin_user_sw;
  assign rise = b_s[1] & ~b_s[2];
  assign chg = rise & fv & (f_s[1] != fl);
  assign frise = chg & f_s[1];
  assign red = ~lock;
  // two-flop synchronizers; b_s[2] keeps the previous synchronized bclk for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      b_s <= '0;
      f_s <= '0;
      d_s <= '0;
    end else begin
      b_s <= {b_s[1:0], pin_i2s_bclk};
      f_s <= {f_s[0], pin_i2s_fclk};
      d_s <= {d_s[0], pin_i2s_data};
    end
  // word capture; wv stays low until a word has started on a real fclk change, so partial words are dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fl <= 1'b0;
      fv <= 1'b0;
      wv <= 1'b0;
      bc <= '0;
      w <= '0;
      hl <= '0;
      bl <= '0;
      br <= '0;
    end else if (rise) begin
      fl <= f_s[1];
      fv <= 1'b1;
      if (chg) begin
        if (wv && !fl) hl <= w;
        if (wv && fl) begin
          bl <= hl;
          br <= w;
        end
        wv <= 1'b1;
        w <= {d_s[1], 23'd0};
        bc <= 5'd1;
      end else if (bc < 5'd24) begin
        w[5'd23 - bc] <= d_s[1];
        bc <= bc + 5'd1;
      end
    end
  // lock tracking: period measured between fclk rising changes, timeout on fclk inactivity
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      id <= '0;
      pc <= '0;
      pv <= 1'b0;
      gc <= '0;
      lock <= 1'b0;
    end else begin
      id <= chg ? 8'd0 : (id == 8'hff ? id : id + 8'd1);
      pc <= frise ? 8'd0 : (pc == 8'hff ? pc : pc + 8'd1);
      if (!chg && id == 8'hff) begin
        lock <= 1'b0;
        pv <= 1'b0;
        gc <= '0;
      end else if (frise) begin
        pv <= 1'b1;
        if (pv && pc >= 8'd99 && pc <= 8'd155) begin
          gc <= gc == 2'd3 ? gc : gc + 2'd1;
          if (gc == 2'd3) lock <= 1'b1;
        end else if (pv) gc <= '0;
      end
    end
`ifdef SPDIF_CHSTAT_EN
  assign cb = fr == 8'd2 || fr == 8'd25 || fr == 8'd32 || fr == 8'd33 || fr == 8'd35;
`else
  assign cb = 1'b0;
`endif
  // cell value: preamble pattern relative to the level before the subframe, else biphase-mark of the slot bit
  always_comb begin
    slot = c[5:1];
    pat = c[6] ? 8'b11100100 : (fr == 8'd0 ? 8'b11101000 : 8'b11100010);
    bit_v = (slot >= 5'd4 && slot <= 5'd27) ? smp[slot - 5'd4] :
            slot == 5'd30 ? cb : slot == 5'd31 ? (^smp ^ cb) : 1'b0;
    pre_lvl = c[5:0] == 6'd0 ? pin_opt1 : pl;
    nxt = slot < 5'd4 ? pat[3'd7 - c[2:0]] ^ pre_lvl : (c[0] ? pin_opt1 ^ bit_v : ~pin_opt1);
  end
  // free-running encoder; each subframe's sample is frozen at its first cell
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      c <= '0;
      fr <= '0;
      smp <= '0;
      pl <= 1'b0;
      pin_opt1 <= 1'b0;
    end else begin
      c <= c + 7'd1;
      if (c == 7'd127) fr <= fr == 8'd191 ? 8'd0 : fr + 8'd1;
      if (c[5:0] == 6'd0) begin
        pl <= pin_opt1;
        smp <= lock ? (c[6] ? br : bl) : 24'd0;
      end
      pin_opt1 <= nxt;
    end
endmodule

// File: tb/tb_splitstreamer_core.sv
// tb_splitstreamer_core: drives I2S frames and decodes the S/PDIF stream subframe by subframe
module tb_splitstreamer_core;
  logic clk = 0, rst_n = 0, fclk = 0, bclk = 0, data = 0;
  logic opt, red;
  int total = 0, bad = 0;
  logic [23:0] ql[$], qr[$];
  int ml = 0, mr = 0, mode = 0;
  bit forbid = 0;
  bit cs[192];
  logic cells[64];
  int k = 0, sf = 0, nb = 0;
  logic prev = 0, started = 0;
  logic [7:0] first_pre = 0;
  logic [23:0] last_l = 0, last_r = 0;
  logic [23:0] spec_w = 24'hA5C3E7;

  always #20 clk = ~clk;

  splitstreamer_core dut (
    .pin_i2s_bclk_pll(clk),
    .pin_user_sw(rst_n),
    .pin_i2s_fclk(fclk),
    .pin_i2s_bclk(bclk),
    .pin_i2s_data(data),
    .pin_opt1(opt),
    .red(red)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int find(input logic [23:0] q[$], input int from, input logic [23:0] v);
    for (int j = from; j < q.size(); j++) if (q[j] == v) return j;
    return -1;
  endfunction

  task automatic analyze();
    logic [7:0] pre, ep;
    logic [31:0] bits;
    logic [23:0] a;
    int miss, ones, fno, j;
    bit left;
    left = (sf % 2) == 0;
    fno = (sf / 2) % 192;
    for (int i = 0; i < 8; i++) pre[7-i] = cells[i] ^ prev;
    ep = !left ? 8'b11100100 : (fno == 0 ? 8'b11101000 : 8'b11100010);
    if (sf == 0) first_pre = pre;
    if (pre == 8'b11101000) nb++;
    chk("preamble", {24'd0, pre}, {24'd0, ep});
    miss = 0;
    ones = 0;
    bits = 0;
    for (int s = 4; s < 32; s++) begin
      if (cells[2*s] == cells[2*s-1]) miss++;
      bits[s] = cells[2*s] ^ cells[2*s+1];
      if (bits[s]) ones++;
    end
    chk("slot_edge", miss, 0);
    chk("v_bit", {31'd0, bits[28]}, 0);
    chk("u_bit", {31'd0, bits[29]}, 0);
    chk("c_bit", {31'd0, bits[30]}, {31'd0, cs[fno]});
    chk("parity", ones % 2, 0);
    a = bits[27:4];
    if (left) last_l = a;
    else last_r = a;
    if (mode == 1) begin
      j = left ? find(ql, ml, a) : find(qr, mr, a);
      total++;
      if (j < 0) begin
        bad++;
        $display("FAIL audio_order: %s got %h, not a sent sample at or after index %0d", left ? "left" : "right", a, left ? ml : mr);
      end else if (left) ml = j;
      else mr = j;
    end else if (mode == 2) chk("audio_zero", {8'd0, a}, 0);
    if (forbid) chk("discarded_word", {31'd0, a == spec_w}, 0);
  endtask

  always @(posedge clk) started <= rst_n;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_opt", {31'd0, opt}, 0);
      chk("rst_red", {31'd0, red}, 1);
      k = 0;
      sf = 0;
      prev = 0;
    end else if (started) begin
      cells[k] = opt;
      k++;
      if (k == 64) begin
        analyze();
        k = 0;
        sf++;
        prev = cells[63];
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bclk = 0;
      data = 1'($urandom & 1);
      #40 bclk = 1;
      #40;
    end
  endtask

  task automatic word(input logic ch, input logic [31:0] w, input int rb);
    for (int b = 0; b < 32; b++) begin
      bclk = 0;
      fclk = ch;
      data = w[31-b];
      if (rb >= 0 && b == rb) rst_n = 0;
      if (rb >= 0 && b == rb + 2) rst_n = 1;
      #40 bclk = 1;
      #40;
    end
  endtask

  task automatic frame(input logic [31:0] l, input logic [31:0] r, input int rb);
    word(1'b0, l, rb);
    word(1'b1, r, -1);
    ql.push_back(l[31:8]);
    qr.push_back(r[31:8]);
  endtask

  initial begin
    for (int i = 0; i < 192; i++) cs[i] = 0;
`ifdef SPDIF_CHSTAT_EN
    cs[2] = 1;
    {cs[24], cs[25], cs[26], cs[27]} = 4'b0100;
    cs[32] = 1;
    {cs[33], cs[34], cs[35]} = 3'b101;
`endif
    rst_n = 0;
    @(posedge clk);
    #7;
    idle(2);
    rst_n = 1;
    idle(8);
    for (int f = 1; f <= 10; f++) begin
      frame(32'h12345678, 32'h9ABCDEF0, -1);
      if (f == 4) chk("red_before_lock", {31'd0, red}, 1);
      if (f == 5) chk("red_locked", {31'd0, red}, 0);
      if (f == 8) mode = 1;
    end
    chk("first_preamble", {24'd0, first_pre}, 32'hE8);
    chk("left_const", {8'd0, last_l}, 32'h123456);
    chk("right_const", {8'd0, last_r}, 32'h9ABCDE);
    for (int f = 0; f < 10; f++) frame($urandom, $urandom, -1);
    mode = 0;
    idle(150);
    chk("red_unlock", {31'd0, red}, 1);
    idle(65);
    mode = 2;
    idle(200);
    chk("zero_left", {8'd0, last_l}, 0);
    chk("zero_right", {8'd0, last_r}, 0);
    for (int i = 0; i < 20000 && sf < 388; i++) idle(1);
    chk("frames_reached", {31'd0, sf >= 388}, 1);
    chk("b_count", nb, 2);
    mode = 0;
    for (int f = 0; f < 6; f++) frame($urandom, $urandom, -1);
    frame({spec_w, 8'h5A}, $urandom, 10);
    ml = ql.size();
    mr = qr.size();
    forbid = 1;
    for (int f = 1; f <= 10; f++) begin
      frame($urandom, $urandom, -1);
      if (f == 8) mode = 1;
    end
    chk("red_relocked", {31'd0, red}, 0);
    idle(64);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
